// File: rtl/psum_out_buffer.sv
// psum_out_buffer: circular FIFO between the buffer write controller and the
// output-memory writer. The write side is throttled by `ready` (= !full).
// The read side is a first-word-fall-through valid/ready port.
// Optional feature macro: PSUM_BUF_OVF_EN adds a sticky overflow flag `ovf`.
// Every handshake output is a direct decode of the registered count, so
// out_ready has no combinational path to ready.
module psum_out_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wen,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
`ifdef PSUM_BUF_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [ADDR_W:0]   r_count;

  logic w_full, w_empty, w_push, w_pop;

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_push  = wen & ~w_full;
  assign w_pop   = out_ready & ~w_empty;

  assign ready     = ~w_full;
  assign out_valid = ~w_empty;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign out_data  = r_mem[r_rd_ptr];

  // Storage write; the array is not reset, so stale contents stay after a flush
  always_ff @(posedge clk) begin
    if (w_push && !clr) r_mem[r_wr_ptr] <= wdata;
  end

  // Pointers and occupancy; the flush overrides any push/pop in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef PSUM_BUF_OVF_EN
  logic r_ovf;
  assign ovf = r_ovf;

  // Sticky flag: a write was attempted while the buffer was full
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_ovf <= 1'b0;
    else if (clr)            r_ovf <= 1'b0;
    else if (wen && w_full)  r_ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_psum_out_buffer.sv
// Testbench for psum_out_buffer: directed scenarios followed by random traffic.
// The reference model is a plain queue; a negedge monitor compares every DUT
// output against it and then applies that cycle's inputs to the model.
module tb_psum_out_buffer;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst, clr, wen, out_ready;
  logic [DATA_W-1:0] wdata;
  logic              ready, out_valid, full, empty;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W:0]   count;
`ifdef PSUM_BUF_OVF_EN
  logic              ovf;
`endif

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] q[$];
  logic              m_ovf = 1'b0;

  psum_out_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wen(wen), .wdata(wdata),
    .ready(ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count), .full(full), .empty(empty)
`ifdef PSUM_BUF_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Async reset empties the model at once, whatever the clock is doing
  always @(negedge rst) begin
    q.delete();
    m_ovf = 1'b0;
  end

  // Monitor: compare outputs against the model, then apply this cycle's inputs
  always @(negedge clk) begin
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("ready", 32'(ready), 32'(n != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(n != 0));
`ifdef PSUM_BUF_OVF_EN
    chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
    if (n > 0) chk("out_data", 32'(out_data), 32'(q[0]));
    if (rst) begin
      if (clr) begin
        q.delete();
        m_ovf = 1'b0;
      end else begin
        if (wen && n == DEPTH) m_ovf = 1'b1;
        if (out_ready && n > 0) void'(q.pop_front());
        if (wen && n < DEPTH) q.push_back(wdata);
      end
    end
  end

  task automatic cyc(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
    @(posedge clk); #1;
    wen = w; wdata = d; out_ready = r; clr = c;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; wen = 1'b0; out_ready = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;

    // Fill to DEPTH, then one write that must be dropped
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, DATA_W'(16'h0011 + i), 1'b0, 1'b0);
    cyc(1'b1, 16'h0099, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("fill_count", 32'(count), 32'(DEPTH));
    chk("fill_ready", 32'(ready), 32'd0);
`ifdef PSUM_BUF_OVF_EN
    chk("ovf_set", 32'(ovf), 32'd1);
`endif

    // Drain in order, with two extra pops while empty
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("drain_empty", 32'(empty), 32'd1);

    // Concurrent push/pop at count=3 across pointer wrap
    for (int i = 0; i < 3; i++) cyc(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, DATA_W'($urandom), 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("conc_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);

    // Full with simultaneous pop: write is dropped
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    cyc(1'b1, 16'h00AA, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("fullpop_count", 32'(count), 32'(DEPTH - 1));
    chk("fullpop_ready", 32'(ready), 32'd1);
    for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, '0, 1'b1, 1'b0);

    // Overflow, drain to 5, then flush with a concurrent write
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 5; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 16'h0055, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_empty", 32'(empty), 32'd1);
`ifdef PSUM_BUF_OVF_EN
    chk("clr_ovf", 32'(ovf), 32'd0);
`endif

    // Async reset between edges with a write in flight
    for (int i = 0; i < 5; i++) cyc(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    cyc(1'b1, 16'h0077, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_full", 32'(full), 32'd0);
    #1;
    rst = 1'b1; wen = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 100) < 60, DATA_W'($urandom), ($urandom % 100) < 50, ($urandom % 100) < 3);
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
